// File: rtl/ap_kernel_host_pkg.sv
// Shared types for the ap_ctrl_hs kernel host.
// State encoding and default widths.
package ap_kernel_host_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_BITS_DEF = 2;

  typedef enum logic [1:0] {
    FILL,
    START,
    WAIT_DONE,
    DRAIN
  } state_t;

endpackage

// File: rtl/ap_mem_bank.sv
// DEPTH x DATA_W flop bank: one write port, one registered
// read port, one combinational read port, synchronous clear.
module ap_mem_bank
  import ap_kernel_host_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_W-1:0]    rq_o,
  input  logic [ADDR_BITS-1:0] caddr_i,
  output logic [DATA_W-1:0]    cq_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rq_q;

  // Storage: clear beats write; registered read returns pre-write data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rq_q <= '0;
    end else begin
      if (clr_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
        rq_q <= mem_q[raddr_i];
      end
    end
  end

  assign rq_o = rq_q;
  assign cq_o = mem_q[caddr_i];

endmodule

// File: rtl/ap_kernel_host.sv
// Host side of an ap_ctrl_hs kernel: stream fill, kernel run
// with ap_memory in/out banks, stream drain.
module ap_kernel_host
  import ap_kernel_host_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_last,
  output logic                 ap_start,
  input  logic                 ap_done,
  input  logic                 ap_idle,
  input  logic                 ap_ready,
  input  logic [ADDR_BITS-1:0] in_r_address0,
  input  logic                 in_r_ce0,
  output logic [DATA_W-1:0]    in_r_q0,
  input  logic [ADDR_BITS-1:0] out_r_address0,
  input  logic                 out_r_ce0,
  input  logic                 out_r_we0,
  input  logic [DATA_W-1:0]    out_r_d0,
  output logic                 busy,
  output logic [31:0]          run_cycles,
  output logic                 protocol_err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic                   s_ready_q;
  logic [31:0]            cnt_q, cnt_d, cnt_inc;
  logic [31:0]            run_q, run_d;
  logic                   err_q, err_d;
  logic                   s_fire, in_run, enter_start, k_wr;
  logic [DATA_W-1:0]      in_cq, out_rq;
  logic                   unused_sig;

  assign s_fire      = s_valid & s_ready_q;
  assign in_run      = (state_q == START) | (state_q == WAIT_DONE);
  assign k_wr        = out_r_ce0 & out_r_we0;
  assign enter_start = (state_q == FILL) & (state_d == START);
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

  // Next state and pointer advance.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      FILL: begin
        if (s_fire) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST) state_d = START;
        end
      end
      START: begin
        if (ap_ready) state_d = ap_done ? DRAIN : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ap_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (m_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == LAST) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Run timer, latched result and sticky protocol error.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    err_d = err_q;
    if (enter_start) cnt_d = '0;
    else if (in_run) cnt_d = cnt_inc;
    if (in_run & ap_done) run_d = cnt_inc;
    if (~in_run & (k_wr | in_r_ce0 | ap_done)) err_d = 1'b1;
    if (ap_ready & (state_q != START)) err_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= FILL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b0;
      cnt_q     <= '0;
      run_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= (state_d == FILL);
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      err_q     <= err_d;
    end
  end

  ap_mem_bank #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_W   (DATA_W)
  ) u_in_bank (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .clr_i  (1'b0),
    .we_i   (s_fire),
    .waddr_i(wr_ptr_q),
    .wdata_i(s_data),
    .re_i   (in_r_ce0),
    .raddr_i(in_r_address0),
    .rq_o   (in_r_q0),
    .caddr_i('0),
    .cq_o   (in_cq)
  );

  ap_mem_bank #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_W   (DATA_W)
  ) u_out_bank (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .clr_i  (enter_start),
    .we_i   (k_wr & in_run),
    .waddr_i(out_r_address0),
    .wdata_i(out_r_d0),
    .re_i   (1'b0),
    .raddr_i('0),
    .rq_o   (out_rq),
    .caddr_i(rd_ptr_q),
    .cq_o   (m_data)
  );

  assign unused_sig   = ^{in_cq, out_rq, ap_idle};

  assign s_ready      = s_ready_q;
  assign m_valid      = (state_q == DRAIN);
  assign m_last       = m_valid & (rd_ptr_q == LAST);
  assign ap_start     = (state_q == START);
  assign busy         = (state_q != FILL);
  assign run_cycles   = run_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_ap_kernel_host.sv
// Directed bench for ap_kernel_host with a small
// kernel model computing out[i] = in[i] + 1.
module tb_ap_kernel_host;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        ap_start;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b1;
  logic        ap_ready = 1'b0;
  logic [1:0]  in_r_address0 = '0;
  logic        in_r_ce0 = 1'b0;
  logic [31:0] in_r_q0;
  logic [1:0]  out_r_address0 = '0;
  logic        out_r_ce0 = 1'b0;
  logic        out_r_we0 = 1'b0;
  logic [31:0] out_r_d0 = '0;
  logic        busy;
  logic [31:0] run_cycles;
  logic        protocol_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] q_pre [4];
  logic [31:0] q_got [4];
  logic [31:0] q_hold[4];
  logic [31:0] got   [4];
  logic        got_last[4];

  ap_kernel_host dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .in_r_address0 (in_r_address0),
    .in_r_ce0      (in_r_ce0),
    .in_r_q0       (in_r_q0),
    .out_r_address0(out_r_address0),
    .out_r_ce0     (out_r_ce0),
    .out_r_we0     (out_r_we0),
    .out_r_d0      (out_r_d0),
    .busy          (busy),
    .run_cycles    (run_cycles),
    .protocol_err  (protocol_err)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset;
    s_valid = 0; m_ready = 0; ap_done = 0; ap_ready = 0;
    in_r_ce0 = 0; out_r_ce0 = 0; out_r_we0 = 0;
    ap_rst_n = 0;
    tick;
    tick;
    ap_rst_n = 1;
    tick;
  endtask

  task automatic send4(input logic [31:0] a, b, c, d);
    logic [31:0] w[4];
    int n;
    w = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      s_valid = 1;
      s_data = w[i];
      n = 0;
      while (!s_ready && n < 20) begin
        tick;
        n++;
      end
      if (!s_ready) begin
        tests++; fails++;
        $display("FAIL send_timeout: word %0d s_ready=%b required 1", i, s_ready);
      end
      tick;
    end
    s_valid = 0;
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n = 0;
    while (!ap_start && n < 20) begin
      tick;
      n++;
    end
    ok = ap_start;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL start_timeout: ap_start=%b required 1", ap_start);
    end
  endtask

  task automatic kernel_run;
    bit ok;
    wait_start(ok);
    if (!ok) return;
    ap_ready = 1;
    tick;
    ap_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_r_address0 = 2'(i);
      in_r_ce0 = 1;
      q_pre[i] = in_r_q0;
      tick;
      in_r_ce0 = 0;
      q_got[i] = in_r_q0;
      out_r_address0 = 2'(i);
      out_r_d0 = q_got[i] + 32'd1;
      out_r_ce0 = 1;
      out_r_we0 = 1;
      tick;
      out_r_ce0 = 0;
      out_r_we0 = 0;
      q_hold[i] = in_r_q0;
    end
    repeat (3) tick;
    ap_done = 1;
    tick;
    ap_done = 0;
  endtask

  task automatic drain4(input bit toggle);
    int n, cyc;
    logic [31:0] d;
    logic rdy;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      if (!m_valid) begin
        m_ready = 0;
        tick;
        cyc++;
        continue;
      end
      m_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      rdy = m_ready;
      d = m_data;
      if (rdy) begin
        got[n] = d;
        got_last[n] = m_last;
        n++;
      end
      tick;
      cyc++;
      if (!rdy) begin
        tests++;
        if (m_valid !== 1'b1 || m_data !== d) begin
          fails++;
          $display("FAIL stall_hold: m_valid=%b m_data=%0d required 1 %0d",
                   m_valid, m_data, d);
        end
      end
    end
    m_ready = 0;
    if (n < 4) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d words required 4", n);
    end
  endtask

  task automatic check_drain(input logic [31:0] e0, e1, e2, e3);
    tests++;
    if ({got[0], got[1], got[2], got[3]} !== {e0, e1, e2, e3}) begin
      fails++;
      $display("FAIL drain_data: got %0d %0d %0d %0d required %0d %0d %0d %0d",
               got[0], got[1], got[2], got[3], e0, e1, e2, e3);
    end
    tests++;
    if ({got_last[0], got_last[1], got_last[2], got_last[3]} !== 4'b0001) begin
      fails++;
      $display("FAIL drain_last: got %b%b%b%b required 0001",
               got_last[0], got_last[1], got_last[2], got_last[3]);
    end
  endtask

  task automatic test_reset;
    #2 ap_rst_n = 0;
    tick;
    tests++;
    if ({s_ready, m_valid, m_last, ap_start, busy, protocol_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000000",
               {s_ready, m_valid, m_last, ap_start, busy, protocol_err});
    end
    tests++;
    if ({m_data, in_r_q0, run_cycles} !== 96'd0) begin
      fails++;
      $display("FAIL reset_data: m_data=%0d q0=%0d run=%0d required 0 0 0",
               m_data, in_r_q0, run_cycles);
    end
    ap_rst_n = 1;
    tick;
    tests++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: s_ready=%b busy=%b required 1 0", s_ready, busy);
    end
  endtask

  task automatic test_basic;
    send4(32'd10, 32'd20, 32'd30, 32'd40);
    tests++;
    if (ap_start !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_start: ap_start=%b busy=%b s_ready=%b required 1 1 0",
               ap_start, busy, s_ready);
    end
    kernel_run;
    tests++;
    if (run_cycles !== 32'd13) begin
      fails++;
      $display("FAIL basic_run_cycles: got %0d required 13", run_cycles);
    end
    drain4(1'b0);
    check_drain(32'd11, 32'd21, 32'd31, 32'd41);
    tests++;
    if (busy !== 1'b0 || s_ready !== 1'b1 || protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_end: busy=%b s_ready=%b err=%b required 0 1 0",
               busy, s_ready, protocol_err);
    end
  endtask

  task automatic test_read_latency;
    tests++;
    if (q_pre[2] !== 32'd20) begin
      fails++;
      $display("FAIL rd_before: got %0d required 20", q_pre[2]);
    end
    tests++;
    if (q_got[2] !== 32'd30 || q_got[0] !== 32'd10) begin
      fails++;
      $display("FAIL rd_latency: got %0d %0d required 30 10", q_got[2], q_got[0]);
    end
    tests++;
    if (q_hold[2] !== 32'd30) begin
      fails++;
      $display("FAIL rd_hold: got %0d required 30", q_hold[2]);
    end
  endtask

  task automatic test_backpressure;
    send4(32'd1, 32'd2, 32'd3, 32'd4);
    kernel_run;
    drain4(1'b1);
    check_drain(32'd2, 32'd3, 32'd4, 32'd5);
  endtask

  task automatic test_ready_done;
    bit ok;
    send4(32'd7, 32'd7, 32'd7, 32'd7);
    wait_start(ok);
    ap_ready = 1;
    ap_done = 1;
    tick;
    ap_ready = 0;
    ap_done = 0;
    tests++;
    if (m_valid !== 1'b1 || ap_start !== 1'b0) begin
      fails++;
      $display("FAIL rd_direct_drain: m_valid=%b ap_start=%b required 1 0",
               m_valid, ap_start);
    end
    tests++;
    if (run_cycles !== 32'd1 || protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL rd_run: run=%0d err=%b required 1 0", run_cycles, protocol_err);
    end
    drain4(1'b0);
    check_drain(32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_errors;
    bit ok;
    do_reset;
    out_r_address0 = 2'd0;
    out_r_d0 = 32'hDEAD;
    out_r_ce0 = 1;
    out_r_we0 = 1;
    tick;
    out_r_ce0 = 0;
    out_r_we0 = 0;
    tests++;
    if (protocol_err !== 1'b1) begin
      fails++;
      $display("FAIL err_fill_write: got %b required 1", protocol_err);
    end
    send4(32'd3, 32'd3, 32'd3, 32'd3);
    wait_start(ok);
    ap_ready = 1;
    ap_done = 1;
    tick;
    ap_ready = 0;
    ap_done = 0;
    out_r_ce0 = 1;
    out_r_we0 = 1;
    tick;
    out_r_ce0 = 0;
    out_r_we0 = 0;
    tests++;
    if (m_data !== 32'd0) begin
      fails++;
      $display("FAIL err_drain_drop: m_data=%0h required 0", m_data);
    end
    drain4(1'b0);
    check_drain(32'd0, 32'd0, 32'd0, 32'd0);
    tests++;
    if (protocol_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %b required 1", protocol_err);
    end
    do_reset;
    tests++;
    if (protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL err_cleared: got %b required 0", protocol_err);
    end
    ap_ready = 1;
    tick;
    ap_ready = 0;
    tests++;
    if (protocol_err !== 1'b1) begin
      fails++;
      $display("FAIL err_ready_no_start: got %b required 1", protocol_err);
    end
    do_reset;
    ap_done = 1;
    tick;
    ap_done = 0;
    tests++;
    if (protocol_err !== 1'b1) begin
      fails++;
      $display("FAIL err_done_fill: got %b required 1", protocol_err);
    end
    do_reset;
    s_valid = 1;
    s_data = 32'd55;
    tick;
    s_valid = 0;
    in_r_address0 = 2'd0;
    in_r_ce0 = 1;
    tick;
    in_r_ce0 = 0;
    tests++;
    if (in_r_q0 !== 32'd55 || protocol_err !== 1'b1) begin
      fails++;
      $display("FAIL err_fill_read: q0=%0d err=%b required 55 1", in_r_q0, protocol_err);
    end
  endtask

  task automatic test_reset_midrun;
    bit ok;
    do_reset;
    send4(32'd1, 32'd2, 32'd3, 32'd4);
    wait_start(ok);
    ap_rst_n = 0;
    #1;
    tests++;
    if (ap_start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_start_async: ap_start=%b busy=%b required 0 0", ap_start, busy);
    end
    do_reset;
    send4(32'd1, 32'd2, 32'd3, 32'd4);
    wait_start(ok);
    ap_ready = 1;
    tick;
    ap_ready = 0;
    tests++;
    if (busy !== 1'b1 || ap_start !== 1'b0) begin
      fails++;
      $display("FAIL rst_wait_state: busy=%b ap_start=%b required 1 0", busy, ap_start);
    end
    ap_rst_n = 0;
    #1;
    tests++;
    if (busy !== 1'b0 || ap_start !== 1'b0) begin
      fails++;
      $display("FAIL rst_wait_async: busy=%b ap_start=%b required 0 0", busy, ap_start);
    end
    tick;
    ap_rst_n = 1;
    tick;
    tests++;
    if (s_ready !== 1'b1 ||
        {m_valid, m_last, ap_start, busy, protocol_err} !== 5'b0 ||
        {m_data, in_r_q0, run_cycles} !== 96'd0) begin
      fails++;
      $display("FAIL rst_after: s_ready=%b flags=%b data=%0d q0=%0d run=%0d required 1 00000 0 0 0",
               s_ready, {m_valid, m_last, ap_start, busy, protocol_err},
               m_data, in_r_q0, run_cycles);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_read_latency;
    test_backpressure;
    test_ready_done;
    test_errors;
    test_reset_midrun;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
